// File: rtl/vcc_pkg.sv
// Shared definitions for the accumulator/counter update stage of the coder.
// Width defaults, adaptive-statistics constants and the FSM state encoding.
package vcc_pkg;

    localparam int K_DEF           = 13;
    localparam int ACC_WIDTH_DEF   = 29;
    localparam int P_WIDTH_DEF     = 8;
    localparam int CNT49_WIDTH_DEF = 14;
    localparam int D_WIDTH_DEF     = 16;
    localparam int GAMMA0_DEF      = 1;
    localparam int GAMMA_STAR_DEF  = 6;
    localparam int ACC_INIT_DEF    = 100;
    localparam int MUL49           = 49;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } vcc_state_e;

endpackage

// File: rtl/vcc_acc_sat.sv
// Combinational accumulator next-value: S = acc + 4*mqi, saturated, plus the
// rounded halving used when the counter rescales.
module vcc_acc_sat #(
    parameter int ACC_WIDTH = 29,
    parameter int D_WIDTH   = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [D_WIDTH-1:0]   mqi,
    output logic [ACC_WIDTH-1:0] acc_sum,
    output logic [ACC_WIDTH-1:0] acc_half,
    output logic                 lsb
);

    localparam int SW = ACC_WIDTH + 1;

    logic [SW-1:0] sum;
    logic [SW:0]   sum_inc;
    logic [SW-1:0] half;

    assign sum     = SW'(acc) + (SW'(mqi) << 2);
    assign sum_inc = {1'b0, sum} + {{SW{1'b0}}, 1'b1};
    assign half    = sum_inc[SW:1];

    // Any carry into the top bit means the true value exceeds the register range.
    assign acc_sum  = sum[SW-1]       ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    assign acc_half = half[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : half[ACC_WIDTH-1:0];
    assign lsb      = sum[0];

endmodule

// File: rtl/vcc_acc_upd.sv
// Adaptive statistics update: counter, 49*counter and accumulator for the next
// sample, with periodic rescale. One-cycle latency; state exposed on 'state'.
module vcc_acc_upd
    import vcc_pkg::*;
#(
    parameter int K           = K_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int P_WIDTH     = P_WIDTH_DEF,
    parameter int CNT49_WIDTH = CNT49_WIDTH_DEF,
    parameter int D_WIDTH     = D_WIDTH_DEF,
    parameter int GAMMA0      = GAMMA0_DEF,
    parameter int GAMMA_STAR  = GAMMA_STAR_DEF,
    parameter int ACC_INIT    = ACC_INIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   en_i,
    input  logic [D_WIDTH-1:0]     mqi_i,
    output logic                   valid_o,
    output logic [P_WIDTH-1:0]     pcnt_o,
    output logic [CNT49_WIDTH-1:0] cnt49_o,
    output logic [ACC_WIDTH-1:0]   acc_o,
    output logic                   rescale_o,
    output logic                   rbit_o,
    output vcc_state_e             state
);

    localparam logic [P_WIDTH-1:0]     PCNT_INIT = P_WIDTH'(2**GAMMA0);
    localparam logic [P_WIDTH-1:0]     PCNT_TOP  = P_WIDTH'(2**GAMMA_STAR - 1);
    localparam logic [P_WIDTH-1:0]     PCNT_HALF = P_WIDTH'(2**(GAMMA_STAR - 1));
    localparam logic [CNT49_WIDTH-1:0] C49_INIT  = CNT49_WIDTH'(MUL49 * 2**GAMMA0);
    localparam logic [CNT49_WIDTH-1:0] C49_HALF  = CNT49_WIDTH'(MUL49 * 2**(GAMMA_STAR - 1));
    localparam logic [CNT49_WIDTH-1:0] C49_STEP  = CNT49_WIDTH'(MUL49);
    localparam logic [ACC_WIDTH-1:0]   ACC_RST   = ACC_WIDTH'(ACC_INIT);

    if (K < 1 || GAMMA0 >= GAMMA_STAR || GAMMA_STAR > P_WIDTH ||
        D_WIDTH + 2 > ACC_WIDTH + 1) begin : g_bad_param
        $error("vcc_acc_upd: illegal parameter combination");
    end

    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc_half;
    logic                 sum_lsb;

    vcc_acc_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .D_WIDTH   (D_WIDTH)
    ) u_sat (
        .acc      (acc_o),
        .mqi      (mqi_i),
        .acc_sum  (acc_sum),
        .acc_half (acc_half),
        .lsb      (sum_lsb)
    );

    // start_i takes priority in every state; a sample arriving with it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            valid_o   <= 1'b0;
            pcnt_o    <= '0;
            cnt49_o   <= '0;
            acc_o     <= '0;
            rescale_o <= 1'b0;
            rbit_o    <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            rescale_o <= 1'b0;
            rbit_o    <= 1'b0;
            if (start_i) begin
                state <= ST_INIT;
            end else begin
                case (state)
                    ST_INIT: begin
                        pcnt_o  <= PCNT_INIT;
                        cnt49_o <= C49_INIT;
                        acc_o   <= ACC_RST;
                        state   <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (en_i) begin
                            valid_o <= 1'b1;
                            if (pcnt_o == PCNT_TOP) begin
                                acc_o     <= acc_half;
                                pcnt_o    <= PCNT_HALF;
                                cnt49_o   <= C49_HALF;
                                rescale_o <= 1'b1;
                                rbit_o    <= sum_lsb;
                            end else begin
                                acc_o   <= acc_sum;
                                pcnt_o  <= pcnt_o + 1'b1;
                                cnt49_o <= cnt49_o + C49_STEP;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vcc_acc_upd.sv
// Bench for vcc_acc_upd: a default instance and a narrow-accumulator instance
// (reaches saturation) share stimulus and are checked against an arithmetic model.
module tb_vcc_acc_upd;
    import vcc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic [15:0] mqi = '0;

    logic        v0, v1, r0, r1, b0, b1;
    logic [7:0]  p0, p1;
    logic [13:0] c0, c1;
    logic [28:0] a0;
    logic [19:0] a1;
    vcc_state_e  s0, s1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    vcc_acc_upd dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .en_i(en), .mqi_i(mqi),
        .valid_o(v0), .pcnt_o(p0), .cnt49_o(c0), .acc_o(a0),
        .rescale_o(r0), .rbit_o(b0), .state(s0)
    );

    vcc_acc_upd #(.ACC_WIDTH(20)) dut_s (
        .clk(clk), .rst_n(rst_n), .start_i(start), .en_i(en), .mqi_i(mqi),
        .valid_o(v1), .pcnt_o(p1), .cnt49_o(c1), .acc_o(a1),
        .rescale_o(r1), .rbit_o(b1), .state(s1)
    );

    // ---------------- behavioural model ----------------
    longint amax [2] = '{(64'd1 << 29) - 1, (64'd1 << 20) - 1};
    longint m_acc [2] = '{0, 0};
    bit     m_rbit [2] = '{0, 0};
    longint m_pcnt = 0;
    bit     m_valid = 0, m_resc = 0, m_live = 0, m_load = 0;

    function automatic longint upd_acc(longint a, longint q, longint mx, bit resc);
        longint s = a + 4 * q;
        longint r = resc ? (s + 1) / 2 : s;
        return (r > mx) ? mx : r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '{0, 0}; m_rbit <= '{0, 0}; m_pcnt <= 0;
            m_valid <= 0; m_resc <= 0; m_live <= 0; m_load <= 0;
        end else if (start) begin
            m_load <= 1; m_valid <= 0; m_resc <= 0; m_rbit <= '{0, 0};
        end else if (m_load) begin
            m_load <= 0; m_live <= 1; m_pcnt <= 2; m_acc <= '{100, 100};
            m_valid <= 0; m_resc <= 0; m_rbit <= '{0, 0};
        end else if (m_live && en) begin
            m_valid <= 1;
            m_resc  <= (m_pcnt == 63);
            m_pcnt  <= (m_pcnt == 63) ? 32 : m_pcnt + 1;
            for (int i = 0; i < 2; i++) begin
                m_acc[i]  <= upd_acc(m_acc[i], longint'(mqi), amax[i], m_pcnt == 63);
                m_rbit[i] <= (m_pcnt == 63) ? bit'((m_acc[i] + 4 * longint'(mqi)) % 2) : 1'b0;
            end
        end else begin
            m_valid <= 0; m_resc <= 0; m_rbit <= '{0, 0};
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid",    v0, m_valid);
            check("valid_s",  v1, m_valid);
            check("pcnt",     p0, m_pcnt);
            check("pcnt_s",   p1, m_pcnt);
            check("cnt49",    c0, 49 * m_pcnt);
            check("cnt49_s",  c1, 49 * m_pcnt);
            check("acc",      a0, m_acc[0]);
            check("acc_s",    a1, m_acc[1]);
            check("rescale",  r0, m_resc);
            check("rescale_s", r1, m_resc);
            check("rbit",     b0, m_rbit[0]);
            check("rbit_s",   b1, m_rbit[1]);
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit st, input bit e, input int unsigned q);
        start = st; en = e; mqi = 16'(q);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic upd_n(input int n, input int unsigned q);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, q);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_acc", a0, 0);
        check("rst_pcnt", p0, 0);
        check("rst_valid", v0, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        cycle(0, 1, 7);                         // IDLE ignores en
        check("idle_valid", v0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 9);                         // INIT ignores en
        check("init_acc", a0, 100);
        check("init_cnt49", c0, 98);
        check("init_valid", v0, 0);
        cycle(0, 1, 5);
        check("first_valid", v0, 1);
        check("first_acc", a0, 120);
        check("first_pcnt", p0, 3);
        check("first_cnt49", c0, 147);

        cycle(0, 1, 43);
        upd_n(59, 3);
        check("pre_resc_acc", a0, 1000);
        check("pre_resc_pcnt", p0, 63);
        cycle(0, 1, 2);
        check("resc_acc", a0, 504);
        check("resc_pcnt", p0, 32);
        check("resc_cnt49", c0, 1568);
        check("resc_flag", r0, 1);
        check("resc_rbit", b0, 0);

        upd_n(31, 0); cycle(0, 1, 1);           // -> 254
        upd_n(31, 0); cycle(0, 1, 1);           // -> 129
        cycle(0, 1, 218); upd_n(30, 0);
        check("odd_acc", a0, 1001);
        cycle(0, 1, 2);
        check("odd_resc_acc", a0, 505);
        check("odd_resc_rbit", b0, 1);
        check("odd_resc_flag", r0, 1);
        cycle(0, 0, 0);
        check("hold_acc", a0, 505);
        check("hold_rescale", r0, 0);

        cycle(1, 1, 50);                        // start beats en
        check("start_en_valid", v0, 0);
        check("start_en_acc", a0, 505);
        cycle(0, 0, 0);
        check("restart_acc", a0, 100);
        check("restart_pcnt", p0, 2);
        check("restart_cnt49", c0, 98);

        upd_n(10, 65535);
        check("sat_acc_s", a1, (1 << 20) - 1);
        check("big_acc", a0, 2621500);
        cycle(0, 1, 100);
        check("sat_nowrap_s", a1, (1 << 20) - 1);
        check("big_acc2", a0, 2621900);

        start = 0; en = 1; mqi = 3;
        #2 rst_n = 1'b0;
        #1;
        check("async_acc", a0, 0);
        check("async_pcnt", p0, 0);
        check("async_cnt49", c0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        upd_n(3, 4);
        check("post_rst_valid", v0, 0);
        check("post_rst_acc", a0, 0);
        cycle(1, 0, 0); cycle(0, 0, 0);
        check("post_rst_init", a0, 100);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 50));
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
